// File: rtl/mat_scan_rx.sv
//==============================================================================
// Module      : mat_scan_rx
// Description : Reassembles 8x8 red/green LED-matrix scan rows into 64-bit
//               frames and flags row-sequence and colour errors.
//               Optional error counter: define MAT_SCAN_RX_ERRCNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mat_scan_rx #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       row,
   input  logic [7:0]       col_r,
   input  logic [7:0]       col_g,
   output logic [63:0]      frame,
   output logic             frame_color,
   output logic             frame_valid,
   output logic             seq_err,
   output logic             col_err,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [0:0] {
      HUNT = 1'b0,
      CAPT = 1'b1
   } state_t;

   state_t          r_state;
   logic [7:0]      r_exp;
   logic [2:0]      r_idx;
   logic [7:0][7:0] r_slot;
   logic            r_clr_set;
   logic            r_clr;

   logic [7:0] w_data;
   logic       w_r_nz;
   logic       w_g_nz;
   logic       w_both;
   logic       w_opp;
   logic       w_start;
   logic       w_match;
   logic       w_seq_ev;
   logic       w_col_ev;

   assign w_data  = col_r | col_g;
   assign w_r_nz  = |col_r;
   assign w_g_nz  = |col_g;
   assign w_both  = w_r_nz & w_g_nz;
   assign w_opp   = r_clr_set & ((r_clr & w_r_nz) | (~r_clr & w_g_nz));
   assign w_start = (row == 8'h7f);
   assign w_match = (row == r_exp);

   // Sequence errors take priority, so colour errors only count on accepted rows.
   assign w_seq_ev = (r_state == CAPT) & ~w_match;
   assign w_col_ev = (r_state == HUNT) ? (w_start & w_both)
                                       : (w_match & (w_both | w_opp));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= HUNT;
         r_exp       <= 8'hbf;
         r_idx       <= 3'd6;
         r_slot      <= '0;
         r_clr_set   <= 1'b0;
         r_clr       <= 1'b0;
         frame       <= '0;
         frame_color <= 1'b0;
         frame_valid <= 1'b0;
         seq_err     <= 1'b0;
         col_err     <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         seq_err     <= w_seq_ev;
         col_err     <= w_col_ev;
         case (r_state)
            HUNT: begin
               if (w_start && !w_both) begin
                  r_slot[7] <= w_data;
                  r_clr_set <= |w_data;
                  r_clr     <= w_g_nz;
                  r_exp     <= 8'hbf;
                  r_idx     <= 3'd6;
                  r_state   <= CAPT;
               end
            end
            CAPT: begin
               if (w_match) begin
                  if (w_both || w_opp) begin
                     r_state <= HUNT;
                  end else begin
                     r_slot[r_idx] <= w_data;
                     if (!r_clr_set && (|w_data)) begin
                        r_clr_set <= 1'b1;
                        r_clr     <= w_g_nz;
                     end
                     r_exp <= {1'b1, r_exp[7:1]};
                     r_idx <= r_idx - 3'd1;
                     if (r_idx == 3'd0) begin
                        frame       <= {r_slot[7:1], w_data};
                        frame_color <= r_clr_set ? r_clr : w_g_nz;
                        frame_valid <= 1'b1;
                        r_state     <= HUNT;
                     end
                  end
               end else if (w_start && !w_both) begin
                  // Out-of-order frame start: restart capture from this sample.
                  r_slot[7] <= w_data;
                  r_clr_set <= |w_data;
                  r_clr     <= w_g_nz;
                  r_exp     <= 8'hbf;
                  r_idx     <= 3'd6;
               end else begin
                  r_state <= HUNT;
               end
            end
            default: r_state <= HUNT;
         endcase
      end
   end

`ifdef MAT_SCAN_RX_ERRCNT_EN
   logic [ERR_W-1:0] r_err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if ((w_seq_ev || w_col_ev) && (r_err_cnt != {ERR_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/mat_scan_rx.md
MAT_SCAN_RX -- requirements
Module: mat_scan_rx

Interface
REQ-001 The module SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-002 The module SHALL have input clk, 1 bit: the single clock, all state updates on the rising edge.
REQ-003 The module SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have input row, 8 bits: active-low row select from the 8x8 scanner, one new row per clk.
REQ-005 The module SHALL have input col_r, 8 bits: red column data for the currently selected row.
REQ-006 The module SHALL have input col_g, 8 bits: green column data for the currently selected row.
REQ-007 The module SHALL have output frame, 64 bits: last complete reassembled bitmap; row 0x7f maps to [63:56] and row 0xfe maps to [7:0].
REQ-008 The module SHALL have output frame_color, 1 bit: 0 for red, 1 for green, for the last complete frame.
REQ-009 The module SHALL have output frame_valid, 1 bit: one-cycle pulse when frame and frame_color update.
REQ-010 The module SHALL have output seq_err, 1 bit: one-cycle pulse on a row-sequence violation.
REQ-011 The module SHALL have output col_err, 1 bit: one-cycle pulse on a colour conflict.
REQ-012 The module SHALL have output err_cnt, ERR_W bits: error counter (see Configuration).

Function
REQ-013 The module SHALL implement a two-state FSM: HUNT (waiting for a frame start) and CAPT (capturing a frame).
REQ-014 The expected row sequence SHALL be 7f, bf, df, ef, f7, fb, fd, fe, one row per clk.
REQ-015 In HUNT, a sampled row of 7f SHALL store the column byte into slot 7, latch the colour, set the expected row to bf and enter CAPT.
REQ-016 In HUNT, every other row value (including 00 and ff) SHALL be ignored, with no error raised.
REQ-017 In CAPT, a sampled row equal to the expected row SHALL store the column byte into the matching slot and advance the expected row.
REQ-018 In CAPT, a sampled row of fe matching the expected row SHALL, on the same edge, load frame from the 8 slots, load frame_color, pulse frame_valid for exactly one cycle and return to HUNT.
REQ-019 Frame latency SHALL be one cycle: frame_valid is high in the cycle after the fe sample.
REQ-020 frame and frame_color SHALL hold their values between frame_valid pulses.
REQ-021 In CAPT, a row of 7f arriving out of order SHALL pulse seq_err, discard the partial frame and restart capture with this sample as slot 7 (the FSM stays in CAPT).
REQ-022 In CAPT, any other unexpected row value (00, ff, a non-one-hot value, or an out-of-order row) SHALL pulse seq_err, discard the partial frame and return to HUNT.
REQ-023 The stored column byte SHALL be col_r OR col_g.
REQ-024 The colour SHALL be latched from the first sample in the frame with non-zero data: 1 if col_g is non-zero, otherwise 0.
REQ-025 An all-blank frame SHALL report frame_color = 0.
REQ-026 A sample with both col_r and col_g non-zero SHALL pulse col_err, abort the frame and return to HUNT.
REQ-027 A sample with non-zero data in the colour opposite to the latched colour SHALL pulse col_err, abort the frame and return to HUNT.
REQ-028 If the same sample violates both the row sequence and the colour rules, only seq_err SHALL pulse.
REQ-029 Error pulses SHALL be registered and appear in the cycle after the offending sample.

Reset
REQ-030 While rst is high, the FSM SHALL be in HUNT and frame = 0, frame_color = 0, frame_valid = 0, seq_err = 0, col_err = 0, err_cnt = 0 and all slots = 0.
REQ-031 A rst asserted mid-capture SHALL discard the partial frame and produce no pulse.
REQ-032 After rst is released, the next 7f sample SHALL be capturable.

Configuration
REQ-033 With MAT_SCAN_RX_ERRCNT_EN defined, err_cnt SHALL increment by 1 on each seq_err or col_err pulse and saturate at all-ones.
REQ-034 With MAT_SCAN_RX_ERRCNT_EN undefined, err_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-035 Scenario: reset, then 7f..fe with col_r = 01,02,04,08,10,20,40,80 and col_g = 0 -> one frame_valid pulse, frame = 0102040810204080, frame_color = 0.
REQ-036 Scenario: the same sequence on col_g with col_r = 0, followed by 00 -> frame_color = 1, and 00 in HUNT raises no error.
REQ-037 Scenario: 7f, bf, 7f, bf..fe with data = FF -> seq_err pulses once, then a valid frame = FFFFFFFFFFFFFFFF.
REQ-038 Scenario: 7f with col_r = 3C, then bf with col_g = 18 -> col_err pulses, no frame_valid, frame unchanged.
REQ-039 Scenario: 7f, bf, df, then rst pulse, then a full frame of AA -> no pulse before the new frame, and frame = AAAAAAAAAAAAAAAA.
REQ-040 Scenario: 300 consecutive ff samples while in CAPT-triggering patterns 7f, ff repeated, with MAT_SCAN_RX_ERRCNT_EN defined -> err_cnt saturates at FF.
